// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag-register bit positions for the pipelined ALU.
package alu_pkg;

   // Arithmetic group (l = 0)
   localparam logic [1:0] OP_NEG_A = 2'b00;
   localparam logic [1:0] OP_NEG_B = 2'b01;
   localparam logic [1:0] OP_ADD   = 2'b10;
   localparam logic [1:0] OP_INC   = 2'b11;

   // Logic group (l = 1)
   localparam logic [1:0] OP_AND   = 2'b00;
   localparam logic [1:0] OP_OR    = 2'b01;
   localparam logic [1:0] OP_XOR   = 2'b10;
   localparam logic [1:0] OP_NOT   = 2'b11;

   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_S = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: arithmetic group as X+Y+ci, logic group bitwise.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_eff,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             l,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] r,
   output logic             z,
   output logic             c,
   output logic             s,
   output logic             v
);

   localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [WIDTH:0]   sum;

   always_comb begin
      x   = '0;
      y   = '0;
      sum = '0;
      r   = '0;
      c   = 1'b0;
      v   = 1'b0;
      if (!l) begin
         unique case (op)
            OP_NEG_A: begin x = ~a_eff; y = One; end
            OP_NEG_B: begin x = ~b;     y = One; end
            OP_ADD:   begin x = a_eff;  y = b;   end
            OP_INC:   begin x = a_eff;  y = One; end
            default:  begin x = '0;     y = '0;  end
         endcase
         sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
         r   = sum[WIDTH-1:0];
         c   = sum[WIDTH];
         v   = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end else begin
         unique case (op)
            OP_AND:  r = a_eff & b;
            OP_OR:   r = a_eff | b;
            OP_XOR:  r = a_eff ^ b;
            OP_NOT:  r = ~a_eff;
            default: r = '0;
         endcase
      end
      z = (r == '0);
      s = r[WIDTH-1];
   end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU stage with valid/ready handshake, accumulator operand and persistent flags.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             l,
   input  logic [1:0]       op,
   input  logic             cin,
   input  logic             cin_sel,
   input  logic             acc_sel,
   input  logic             flag_we,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic             z,
   output logic             c,
   output logic             s,
   output logic             v,
   output logic [3:0]       flags_q
);

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] r_q;
   logic [3:0]       res_flags_q;
   logic [3:0]       flag_reg_q;
   logic             out_valid_q;

   logic [WIDTH-1:0] a_eff;
   logic [WIDTH-1:0] core_r;
   logic             core_z, core_c, core_s, core_v;
   logic             ci;
   logic             accept;

   assign a_eff    = acc_sel ? acc_q : a;
   // Stored carry is read before this edge's update, so chaining needs no bypass.
   assign ci       = cin_sel ? flag_reg_q[FLAG_C] : cin;
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a_eff (a_eff),
      .b     (b),
      .ci    (ci),
      .l     (l),
      .op    (op),
      .r     (core_r),
      .z     (core_z),
      .c     (core_c),
      .s     (core_s),
      .v     (core_v)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         r_q         <= '0;
         res_flags_q <= '0;
         flag_reg_q  <= '0;
         acc_q       <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         r_q         <= core_r;
         res_flags_q <= {core_z, core_c, core_s, core_v};
         acc_q       <= core_r;
         if (flag_we) begin
            flag_reg_q <= {core_z, core_c, core_s, core_v};
         end
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign r         = r_q;
   assign z         = res_flags_q[FLAG_Z];
   assign c         = res_flags_q[FLAG_C];
   assign s         = res_flags_q[FLAG_S];
   assign v         = res_flags_q[FLAG_V];
   assign flags_q   = flag_reg_q;

endmodule
